// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one async-FIFO write port among NUM_REQ valid/ready requesters.
// Optional per-requester accepted-beat counters are enabled by defining FIFO_WR_ARB_STATS_EN.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                          wclk,
  input  logic                          wrst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]         wdata,
  output logic                          winc,
  input  logic                          wfull,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy
`ifdef FIFO_WR_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]         stat_beats
`endif
);

  localparam int         IDW   = $clog2(NUM_REQ);
  localparam logic [7:0] MAX_B = 8'(MAX_BURST);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [IDW-1:0]        r_rr_ptr;
  logic [IDW-1:0]        r_grant_id;
  logic [7:0]            r_beat_cnt;
  logic [IDW-1:0]        w_sel;
  logic [IDW-1:0]        w_rr_nxt;
  logic                  w_found;
  logic                  w_gvalid;
  logic                  w_glast;
  logic [DATA_WIDTH-1:0] w_gdata;
  logic                  w_accept;
  logic                  w_exit;

  // Requester index base+ofs, wrapped modulo NUM_REQ.
  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int ofs);
    int sum;
    sum = int'(base) + ofs;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return IDW'(sum);
  endfunction

  always_comb begin
    w_found = 1'b0;
    w_sel   = r_rr_ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_found && req_valid[wrap_add(r_rr_ptr, k)]) begin
        w_found = 1'b1;
        w_sel   = wrap_add(r_rr_ptr, k);
      end
    end
  end

  assign w_gvalid = req_valid[r_grant_id];
  assign w_glast  = req_last[r_grant_id];
  assign w_gdata  = req_data[r_grant_id*DATA_WIDTH +: DATA_WIDTH];
  assign w_rr_nxt = wrap_add(r_grant_id, 1);
  assign grant_id = r_grant_id;

  always_ff @(posedge wclk) begin
    if (wrst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_exit      = 1'b0;
    req_ready   = '0;
    winc        = 1'b0;
    busy        = 1'b0;
    wdata       = '0;
    case (r_state)
      S_IDLE: begin
        if (w_found) w_state_nxt = S_BURST;
      end
      S_BURST: begin
        busy                  = 1'b1;
        wdata                 = w_gdata;
        w_accept              = w_gvalid & ~wfull;
        winc                  = w_accept;
        req_ready[r_grant_id] = w_accept;
        // Dropping valid releases the port even while the FIFO is full.
        w_exit = ~w_gvalid | (w_accept & (w_glast | ((r_beat_cnt + 8'd1) == MAX_B)));
        if (w_exit) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (wrst) begin
      w_accept  = 1'b0;
      winc      = 1'b0;
      req_ready = '0;
      busy      = 1'b0;
    end
  end

  always_ff @(posedge wclk) begin
    if (wrst) begin
      r_rr_ptr   <= '0;
      r_grant_id <= '0;
      r_beat_cnt <= '0;
    end else begin
      if (r_state == S_IDLE && w_found) begin
        r_grant_id <= w_sel;
        r_beat_cnt <= '0;
      end
      if (w_accept) r_beat_cnt <= r_beat_cnt + 8'd1;
      if (w_exit)   r_rr_ptr   <= w_rr_nxt;
    end
  end

`ifdef FIFO_WR_ARB_STATS_EN
  logic [15:0] r_stat [NUM_REQ];

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge wclk) begin
    if (wrst) begin
      for (int i = 0; i < NUM_REQ; i++) r_stat[i] <= '0;
    end else if (w_accept) begin
      r_stat[r_grant_id] <= sat_inc16(r_stat[r_grant_id]);
    end
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stat
    assign stat_beats[gi*16 +: 16] = r_stat[gi];
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: a transaction-level model queues expected writes and
// per-cycle status; a monitor on the falling edge pops and compares.
module tb_fifo_wr_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  logic            wclk = 1'b0;
  logic            wrst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    req_last = '0;
  logic            wfull = 1'b0;
  logic [N-1:0]    req_ready;
  logic [DW-1:0]   wdata;
  logic            winc;
  logic [1:0]      grant_id;
  logic            busy;
`ifdef FIFO_WR_ARB_STATS_EN
  logic [N*16-1:0] stat_beats;
`endif

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .wclk(wclk), .wrst(wrst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .wdata(wdata), .winc(winc),
    .wfull(wfull), .grant_id(grant_id), .busy(busy)
`ifdef FIFO_WR_ARB_STATS_EN
    , .stat_beats(stat_beats)
`endif
  );

  always #5 wclk = ~wclk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  typedef struct packed {
    logic         winc;
    logic [N-1:0] ready;
    logic         busy;
    logic [1:0]   gid;
  } cyc_t;

  beat_t         src_q[N][$];
  int            gap[N];
  cyc_t          cyc_q[$];
  logic [DW-1:0] wr_q[$];

  // Reference model: owner<0 means nobody holds the port.
  int m_owner = -1;
  int m_beats = 0;
  int m_rr    = 0;
  int m_gid   = 0;
  int m_stat[N];

  bit rnd_mode = 0;
  bit rst_ctl  = 1;
  bit full_force = 0;
  int full_pct = 0;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic load_burst(input int i, input int n, input bit with_last);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      b.data = DW'($urandom);
      b.last = with_last && (k == n - 1);
      src_q[i].push_back(b);
    end
  endtask

  task automatic load_val(input int i, input logic [DW-1:0] d, input bit l);
    beat_t b;
    b.data = d;
    b.last = l;
    src_q[i].push_back(b);
  endtask

  task automatic step();
    logic [N-1:0]    v;
    logic [N-1:0]    l;
    logic [N*DW-1:0] d;
    logic            f;
    logic            r;
    cyc_t            e;
    int              g;
    bit              acc;
    @(posedge wclk);
    #1;
    if (rnd_mode)
      for (int i = 0; i < N; i++)
        if (src_q[i].size() == 0 && $urandom_range(0, 9) == 0)
          load_burst(i, $urandom_range(1, 6), bit'($urandom_range(0, 1)));
    for (int i = 0; i < N; i++) begin
      v[i] = (src_q[i].size() != 0) && (gap[i] == 0);
      d[i*DW +: DW] = (src_q[i].size() != 0) ? src_q[i][0].data : DW'($urandom);
      l[i] = (src_q[i].size() != 0) ? src_q[i][0].last : 1'b0;
    end
    f = full_force || ($urandom_range(0, 99) < full_pct);
    r = rst_ctl || (rnd_mode && $urandom_range(0, 99) == 0);
    req_valid = v;
    req_data  = d;
    req_last  = l;
    wfull     = f;
    wrst      = r;

    e.gid   = 2'(m_gid);
    e.winc  = 1'b0;
    e.ready = '0;
    e.busy  = 1'b0;
    acc     = 0;
    g       = m_owner;
    if (r) begin
      m_owner = -1;
      m_beats = 0;
      m_rr    = 0;
      m_gid   = 0;
      foreach (m_stat[i]) m_stat[i] = 0;
    end else if (m_owner < 0) begin
      for (int k = 0; k < N; k++)
        if (m_owner < 0 && v[(m_rr + k) % N]) m_owner = (m_rr + k) % N;
      if (m_owner >= 0) begin
        m_gid   = m_owner;
        m_beats = 0;
      end
    end else begin
      e.busy = 1'b1;
      acc    = v[g] && !f;
      if (acc) begin
        e.winc     = 1'b1;
        e.ready[g] = 1'b1;
        wr_q.push_back(src_q[g][0].data);
        m_beats++;
        m_stat[g]++;
      end
      if (!v[g] || (acc && (src_q[g][0].last || m_beats == MB))) begin
        m_owner = -1;
        m_rr    = (g + 1) % N;
      end
      if (acc) void'(src_q[g].pop_front());
    end
    cyc_q.push_back(e);

    for (int i = 0; i < N; i++) if (gap[i] > 0) gap[i]--;
    if (acc && rnd_mode && $urandom_range(0, 3) == 0) gap[g] = $urandom_range(1, 3);
  endtask

  function automatic bit pending();
    if (m_owner >= 0) return 1;
    for (int i = 0; i < N; i++) if (src_q[i].size() != 0) return 1;
    return 0;
  endfunction

  initial begin : monitor
    cyc_t          e;
    logic [DW-1:0] w;
    forever begin
      @(negedge wclk);
      if (cyc_q.size() > 0) begin
        e = cyc_q.pop_front();
        chk("winc", 32'(winc), 32'(e.winc));
        chk("req_ready", 32'(req_ready), 32'(e.ready));
        chk("busy", 32'(busy), 32'(e.busy));
        chk("grant_id", 32'(grant_id), 32'(e.gid));
        if (winc === 1'b1) begin
          if (wr_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wdata: unexpected write %0h, none expected at %0t", wdata, $time);
          end else begin
            w = wr_q.pop_front();
            chk("wdata", 32'(wdata), 32'(w));
          end
        end
      end
    end
  end

  initial begin : driver
    foreach (gap[i]) gap[i] = 0;
    foreach (m_stat[i]) m_stat[i] = 0;
    rst_ctl = 1;
    repeat (3) step();
    rst_ctl = 0;

    // Single requester, three beats ending in last.
    load_val(0, 8'hA1, 1'b0);
    load_val(0, 8'hA2, 1'b0);
    load_val(0, 8'hA3, 1'b1);
    repeat (8) step();

    // All requesters contend without last: MAX_BURST bursts rotate.
    for (int i = 0; i < N; i++) load_burst(i, 12, 0);
    repeat (64) step();

    // FIFO full for five cycles mid-burst.
    load_burst(0, 6, 1);
    repeat (3) step();
    full_force = 1;
    repeat (5) step();
    full_force = 0;
    repeat (10) step();

    // Requester 2 runs dry after two beats, requester 3 waiting.
    load_burst(2, 2, 0);
    load_burst(3, 2, 1);
    repeat (10) step();

    // Reset while requester 1 presents its second beat.
    load_burst(1, 4, 1);
    repeat (2) step();
    rst_ctl = 1;
    step();
    rst_ctl = 0;
    repeat (10) step();

    // Randomized traffic with stalls, releases and occasional reset.
    rnd_mode = 1;
    full_pct = 25;
    repeat (700) step();
    rnd_mode = 0;
    full_pct = 0;

    for (int c = 0; c < 400 && pending(); c++) step();
    chk("drain_done", 32'(pending()), 32'd0);
    repeat (3) step();
    @(negedge wclk);
    #1;
    chk("write_queue_empty", 32'(wr_q.size()), 32'd0);
`ifdef FIFO_WR_ARB_STATS_EN
    for (int i = 0; i < N; i++) chk("stat_beats", 32'(stat_beats[i*16 +: 16]), 32'(m_stat[i]));
    rst_ctl = 1;
    step();
    rst_ctl = 0;
    step();
    @(negedge wclk);
    #1;
    for (int i = 0; i < N; i++) chk("stat_after_rst", 32'(stat_beats[i*16 +: 16]), 32'(m_stat[i]));
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write-port arbiter in the wclk domain of the async FIFO.
- Shares one FIFO write port (wdata/winc/wfull) between NUM_REQ requesters, each using a valid/ready handshake.
- Grants bounded bursts: a requester holds the port for up to MAX_BURST beats, or until it signals last, then priority rotates.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- DATA_WIDTH, 8, FIFO data width; must match the FIFO instance.
- MAX_BURST, 4, max beats per grant (1..255).

Ports:
- wclk  input  1  write-domain clock.
- wrst  input  1  reset, synchronous, active-high.
- req_valid  input  NUM_REQ  per-requester beat valid.
- req_data  input  NUM_REQ*DATA_WIDTH  flat bus; requester i at [i*DATA_WIDTH +: DATA_WIDTH].
- req_last  input  NUM_REQ  final beat of requester's burst.
- req_ready  output  NUM_REQ  beat accepted this cycle when valid&ready.
- wdata  output  DATA_WIDTH  to FIFO wdata.
- winc  output  1  to FIFO winc.
- wfull  input  1  from FIFO wfull (registered in wclk domain).
- grant_id  output  $clog2(NUM_REQ)  current/last granted requester.
- busy  output  1  high in BURST state.

Behaviour:
- Interface: one clock, wclk; reset wrst is synchronous and active-high.
- Reset: state=IDLE, rr_ptr=0, grant_id=0, beat_cnt=0. While wrst=1: winc=0, req_ready=0, busy=0, irrespective of state.
- States: IDLE and BURST.
- IDLE:
  - No transfers; req_ready=0, winc=0.
  - If any req_valid: select the first set bit searching from rr_ptr upward, wrapping modulo NUM_REQ.
  - Register grant_id, clear beat_cnt, go to BURST next edge.
  - One dead cycle per burst is intended.
- BURST, with g=grant_id:
  - req_ready[g] = req_valid[g] & ~wfull; all other ready bits 0.
  - winc = req_valid[g] & ~wfull; wdata = req_data[g] (combinational mux, zero latency).
  - Other requesters' data never reaches wdata. wdata may be driven with winc=0; the FIFO ignores it.
  - Accepted beat (winc=1): beat_cnt++.
- BURST exits to IDLE at the clock edge when any of:
  - an accepted beat has req_last[g]=1;
  - an accepted beat brings beat_cnt to MAX_BURST;
  - req_valid[g]=0 (requester released the port).
- On exit: rr_ptr = (g+1) mod NUM_REQ.
- wfull stall: while wfull=1, no beat accepted, beat_cnt holds, grant holds. Requester keeps valid/data stable per handshake rule.
- Simultaneous events:
  - Last beat and MAX_BURST on the same beat give a single exit.
  - wfull=1 with req_last=1 → not accepted, no exit.
- Requesters must hold req_valid/req_data/req_last stable until accepted. The arbiter does not check this.
- Width: beat_cnt is 8 bits and never exceeds MAX_BURST.
- Reset asserted mid-burst: beat not written. The burst is abandoned with no partial-burst recovery; the FIFO's own reset is separate.
- Starvation bound: a waiting requester is granted within (NUM_REQ-1)*(MAX_BURST+1)+1 cycles of non-full operation.

Optional Feature:
- Macro: FIFO_WR_ARB_STATS_EN.
- Defined:
  - Adds output stat_beats (NUM_REQ*16), one 16-bit saturating counter of accepted beats per requester at [i*16 +: 16].
  - Counters saturate at 16'hFFFF, clear to 0 on wrst, and update one cycle after the accepted beat (registered).
- Undefined: port and counters absent; arbiter behaviour identical.

Test Plan:
- Single requester: req_valid=4'b0001, 3 beats 0xA1,0xA2,0xA3 with last on 0xA3, wfull=0 → one IDLE cycle, then winc high 3 consecutive cycles with wdata A1,A2,A3; IDLE; rr_ptr=1.
- Contention: all 4 valid continuously, no last, MAX_BURST=4, wfull=0 → grants 0,1,2,3,0, each 4 beats followed by 1 idle cycle; busy duty 4/5.
- Full stall: req0 in BURST, wfull=1 for 5 cycles mid-burst → winc=0 and req_ready=0 for 5 cycles, beat_cnt frozen, burst resumes and completes remaining beats.
- Early release: req2 granted, drops req_valid after 2 beats → exit to IDLE next edge, rr_ptr=3; req3 granted next if valid.
- Reset mid-burst: wrst=1 while req1 has beat 2 valid → winc=0 that cycle, state IDLE, grant_id=0 after edge; no write reaches the FIFO.
- With FIFO_WR_ARB_STATS_EN: 10 beats from req0, 3 from req3 → stat_beats shows 10 for req0, 3 for req3, 0 for others; after wrst, all 0.
